// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host transmitter states, command codes and frame layout.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_RTS,
    ST_ACK,
    ST_WAIT_IDLE
  } ps2_state_e;

  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] PS2_RSP_ACK      = 8'hFA;

  // start + 8 data + parity + stop
  localparam int unsigned PS2_FRAME_BITS = 11;

  // Everything after the start bit, LSB first: {stop, odd parity, data}.
  function automatic logic [PS2_FRAME_BITS-2:0] ps2_frame(input logic [7:0] data);
    return {1'b1, ~^data, data};
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// PS/2 line conditioning: 2-flop synchronizers, FILTER_LEN-sample level filter on
// both lines and a single-cycle PS2CLK falling-edge strobe. Shareable with the receiver.
module ps2_line_sync #(
  parameter int unsigned FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clk_raw,
  input  logic i_data_raw,
  output logic o_clk_filt,
  output logic o_data_filt,
  output logic o_clk_fall
);

  localparam int unsigned CW = $clog2(FILTER_LEN + 1);

  // bit 0 = PS2CLK, bit 1 = PS2Data
  logic [1:0]    r_s1;
  logic [1:0]    r_s2;
  logic [1:0]    r_filt;
  logic [CW-1:0] r_cnt [2];
  logic          r_fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1     <= '1;
      r_s2     <= '1;
      r_filt   <= '1;
      r_cnt[0] <= '0;
      r_cnt[1] <= '0;
      r_fall   <= 1'b0;
    end else begin
      r_s1   <= {i_data_raw, i_clk_raw};
      r_s2   <= r_s1;
      r_fall <= 1'b0;
      for (int unsigned k = 0; k < 2; k++) begin
        if (r_s2[k] == r_filt[k]) begin
          r_cnt[k] <= '0;
        end else if (r_cnt[k] == CW'(FILTER_LEN - 1)) begin
          r_filt[k] <= r_s2[k];
          r_cnt[k]  <= '0;
          if (k == 0 && !r_s2[k]) r_fall <= 1'b1;
        end else begin
          r_cnt[k] <= r_cnt[k] + 1'b1;
        end
      end
    end
  end

  assign o_clk_filt  = r_filt[0];
  assign o_data_filt = r_filt[1];
  assign o_clk_fall  = r_fall;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter (inhibit, request-to-send, device-clocked
// frame, acknowledge). Optional watchdog enabled by defining PS2_TX_TIMEOUT_EN.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned CLK_HZ         = 100_000_000,
  parameter int unsigned INHIBIT_CYCLES = 12_000,
  parameter int unsigned TIMEOUT_CYCLES = 2_000_000,
  parameter int unsigned FILTER_LEN     = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  input  logic       ps2clk_in,
  input  logic       ps2data_in,
  output logic       ps2clk_pull,
  output logic       ps2data_pull,
  output logic       rx_hold,
  output logic       tx_done,
  output logic       tx_err
);

  localparam int unsigned INH_W = $clog2(INHIBIT_CYCLES);

  if (CLK_HZ == 0 || INHIBIT_CYCLES < 2 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
    $error("ps2_host_tx: invalid parameter set");
  end

  ps2_state_e                r_state;
  logic [PS2_FRAME_BITS-2:0] r_shift;
  logic [3:0]                r_bitcnt;
  logic [INH_W-1:0]          r_inh_cnt;
  logic                      r_ack;
  logic                      w_clk_filt;
  logic                      w_data_filt;
  logic                      w_clk_fall;

`ifdef PS2_TX_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES);
  logic [TO_W-1:0] r_wd;
`endif

  ps2_line_sync #(
    .FILTER_LEN (FILTER_LEN)
  ) u_sync (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clk_raw   (ps2clk_in),
    .i_data_raw  (ps2data_in),
    .o_clk_filt  (w_clk_filt),
    .o_data_filt (w_data_filt),
    .o_clk_fall  (w_clk_fall)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_shift      <= '0;
      r_bitcnt     <= '0;
      r_inh_cnt    <= '0;
      r_ack        <= 1'b0;
      tx_ready     <= 1'b1;
      ps2clk_pull  <= 1'b0;
      ps2data_pull <= 1'b0;
      rx_hold      <= 1'b0;
      tx_done      <= 1'b0;
      tx_err       <= 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
      r_wd         <= '0;
`endif
    end else begin
      tx_done <= 1'b0;
      tx_err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (tx_valid) begin
            r_shift     <= ps2_frame(tx_data);
            r_bitcnt    <= '0;
            r_inh_cnt   <= '0;
            tx_ready    <= 1'b0;
            rx_hold     <= 1'b1;
            ps2clk_pull <= 1'b1;
            r_state     <= ST_INHIBIT;
          end
        end
        ST_INHIBIT: begin
          r_inh_cnt <= r_inh_cnt + 1'b1;
          // Start bit goes out one cycle early so it overlaps the last inhibit cycle.
          if (r_inh_cnt == INH_W'(INHIBIT_CYCLES - 2)) ps2data_pull <= 1'b1;
          if (r_inh_cnt == INH_W'(INHIBIT_CYCLES - 1)) begin
            ps2clk_pull <= 1'b0;
            r_state     <= ST_RTS;
`ifdef PS2_TX_TIMEOUT_EN
            r_wd        <= '0;
`endif
          end
        end
        ST_RTS: begin
          if (w_clk_fall) begin
            ps2data_pull <= ~r_shift[0];
            r_shift      <= {1'b0, r_shift[PS2_FRAME_BITS-2:1]};
            r_bitcnt     <= r_bitcnt + 1'b1;
            if (r_bitcnt == 4'(PS2_FRAME_BITS - 2)) r_state <= ST_ACK;
          end
        end
        ST_ACK: begin
          if (w_clk_fall) begin
            r_ack   <= ~w_data_filt;
            r_state <= ST_WAIT_IDLE;
          end
        end
        ST_WAIT_IDLE: begin
          if (w_clk_filt && w_data_filt) begin
            tx_done  <= r_ack;
            tx_err   <= ~r_ack;
            tx_ready <= 1'b1;
            rx_hold  <= 1'b0;
            r_state  <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
`ifdef PS2_TX_TIMEOUT_EN
      // Watchdog overrides whatever the state logic above decided this cycle.
      if (r_state == ST_RTS || r_state == ST_ACK || r_state == ST_WAIT_IDLE) begin
        if (r_wd == TO_W'(TIMEOUT_CYCLES - 1)) begin
          ps2clk_pull  <= 1'b0;
          ps2data_pull <= 1'b0;
          tx_done      <= 1'b0;
          tx_err       <= 1'b1;
          tx_ready     <= 1'b1;
          rx_hold      <= 1'b0;
          r_state      <= ST_IDLE;
        end else begin
          r_wd <= r_wd + 1'b1;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Scoreboard bench for ps2_host_tx with a behavioural PS/2 device on the open-drain lines.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int unsigned INH  = 50;
  localparam int unsigned TO   = 5000;
  localparam int unsigned FL   = 8;
  localparam int unsigned HALF = 40;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = '0;
  logic       tx_ready, ps2clk_pull, ps2data_pull, rx_hold, tx_done, tx_err;
  logic       ps2clk_in, ps2data_in;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;

  assign ps2clk_in  = ~(ps2clk_pull | dev_clk_low);
  assign ps2data_in = ~(ps2data_pull | dev_data_low);

  always #5 clk = ~clk;

  ps2_host_tx #(
    .CLK_HZ         (100_000_000),
    .INHIBIT_CYCLES (INH),
    .TIMEOUT_CYCLES (TO),
    .FILTER_LEN     (FL)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tx_valid     (tx_valid),
    .tx_data      (tx_data),
    .tx_ready     (tx_ready),
    .ps2clk_in    (ps2clk_in),
    .ps2data_in   (ps2data_in),
    .ps2clk_pull  (ps2clk_pull),
    .ps2data_pull (ps2data_pull),
    .rx_hold      (rx_hold),
    .tx_done      (tx_done),
    .tx_err       (tx_err)
  );

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       done;
    logic       chk_bits;
  } exp_t;

  exp_t       exp_q[$];
  int         n_checks = 0;
  int         n_fail = 0;
  int         n_pulses = 0;
  int         dev_edges = 0;
  logic       dev_ack = 1'b1;
  logic       dev_silent = 1'b0;
  logic       dev_abort = 1'b0;
  logic [7:0] obs_byte = '0;
  logic       obs_par = 1'b0, obs_stop = 1'b0, obs_start = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  // Device: waits for request-to-send, then clocks 11 bits, sampling on rising edges.
  initial begin : device
    forever begin
      @(negedge clk);
      if (!dev_silent && rx_hold && !ps2clk_pull && ps2data_pull) begin
        repeat (30) @(negedge clk);
        obs_start = ps2data_in;
        for (int k = 1; k <= 11; k++) begin
          if (dev_abort) break;
          if (k == 11 && dev_ack) begin
            dev_data_low = 1'b1;
            repeat (5) @(negedge clk);
          end
          dev_clk_low = 1'b1;
          dev_edges++;
          repeat (HALF) @(negedge clk);
          dev_clk_low = 1'b0;
          if (k <= 8)       obs_byte[k-1] = ps2data_in;
          else if (k == 9)  obs_par  = ps2data_in;
          else if (k == 10) obs_stop = ps2data_in;
          repeat (HALF) @(negedge clk);
        end
        dev_data_low = 1'b0;
      end
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (tx_done || tx_err) begin
        n_pulses++;
        check("pulse_exclusive", 32'(tx_done & tx_err), 32'd0);
        check("ready_with_pulse", 32'(tx_ready), 32'd1);
        check("pulse_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("tx_done", 32'(tx_done), 32'(e.done));
          check("tx_err", 32'(tx_err), 32'(!e.done));
          if (e.chk_bits) begin
            check("start_bit", 32'(obs_start), 32'd0);
            check("data_bits", 32'(obs_byte), 32'(e.data));
            check("parity_bit", 32'(obs_par), 32'(e.par));
            check("stop_bit", 32'(obs_stop), 32'd1);
          end
        end
      end
    end
  end

  task automatic send(input logic [7:0] d, input logic par, input logic done,
                      input logic chk, input logic push);
    exp_t e;
    @(negedge clk);
    check("ready_before_send", 32'(tx_ready), 32'd1);
    tx_data  = d;
    tx_valid = 1'b1;
    if (push) begin
      e.data = d; e.par = par; e.done = done; e.chk_bits = chk;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    check("clk_pull_after_accept", 32'(ps2clk_pull), 32'd1);
    check("ready_low_after_accept", 32'(tx_ready), 32'd0);
    check("rx_hold_after_accept", 32'(rx_hold), 32'd1);
  endtask

  task automatic wait_pulse(input string name);
    int start = n_pulses;
    int i = 0;
    while (n_pulses == start && i < 20000) begin
      @(negedge clk);
      i++;
    end
    repeat (20) @(negedge clk);
    check(name, 32'(n_pulses - start), 32'd1);
    check("ready_after_frame", 32'(tx_ready), 32'd1);
    check("lines_released", 32'({ps2clk_pull, ps2data_pull, rx_hold}), 32'd0);
  endtask

  task automatic wait_edges(input int n);
    int i = 0;
    while (dev_edges < n && i < 20000) begin
      @(negedge clk);
      i++;
    end
    check("device_edge_reached", 32'(dev_edges >= n), 32'd1);
  endtask

  initial begin : stim
    repeat (5) @(negedge clk);
    check("rst_tx_ready", 32'(tx_ready), 32'd1);
    check("rst_pulls", 32'({ps2clk_pull, ps2data_pull}), 32'd0);
    check("rst_rx_hold", 32'(rx_hold), 32'd0);
    check("rst_pulses", 32'({tx_done, tx_err}), 32'd0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    send(PS2_CMD_SET_LEDS, 1'b1, 1'b1, 1'b1, 1'b1);
    wait_pulse("frame_ED");
    send(PS2_CMD_ENABLE, 1'b0, 1'b1, 1'b1, 1'b1);
    wait_pulse("frame_F4");
    send(PS2_CMD_RESET, 1'b1, 1'b1, 1'b1, 1'b1);
    wait_pulse("frame_FF");

    dev_ack = 1'b0;
    send(8'h5A, 1'b1, 1'b0, 1'b1, 1'b1);
    wait_pulse("frame_noack");
    dev_ack = 1'b1;

    dev_edges = 0;
    send(8'hA5, 1'b1, 1'b1, 1'b1, 1'b1);
    wait_edges(3);
    tx_data  = 8'h00;
    tx_valid = 1'b1;
    check("ready_low_in_rts", 32'(tx_ready), 32'd0);
    @(negedge clk);
    tx_valid = 1'b0;
    wait_pulse("frame_A5_ignore_valid");

    begin
      int p0;
      dev_edges = 0;
      send(8'h3C, 1'b0, 1'b1, 1'b1, 1'b0);
      wait_edges(5);
      repeat (20) @(negedge clk);
      p0 = n_pulses;
      rst_n = 1'b0;
      #1;
      check("midreset_pulls", 32'({ps2clk_pull, ps2data_pull}), 32'd0);
      check("midreset_ready_hold", 32'({tx_ready, rx_hold}), 32'b10);
      dev_abort = 1'b1;
      repeat (150) @(negedge clk);
      check("midreset_no_pulse", 32'(n_pulses - p0), 32'd0);
      rst_n = 1'b1;
      dev_abort = 1'b0;
      repeat (20) @(negedge clk);
    end
    send(PS2_CMD_RESET, 1'b1, 1'b1, 1'b1, 1'b1);
    wait_pulse("frame_FF_after_reset");

`ifdef PS2_TX_TIMEOUT_EN
    begin
      int t = 0;
      int i = 0;
      dev_silent = 1'b1;
      send(8'h81, 1'b1, 1'b0, 1'b0, 1'b1);
      while (ps2clk_pull && i < 1000) begin
        @(negedge clk);
        i++;
      end
      while (!tx_err && t < 2 * TO) begin
        @(negedge clk);
        t++;
      end
      check("timeout_latency", 32'(t), 32'(TO));
      check("timeout_lines", 32'({ps2clk_pull, ps2data_pull}), 32'd0);
      repeat (5) @(negedge clk);
      dev_silent = 1'b0;
    end
`endif

    repeat (10) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
